// File: rtl/pla_harness_pkg.sv
// -----------------------------------------------------------------------------
// pla_harness_pkg
// Shared definitions for the PLA benchmark harness stages.
//   sweep_state_e   : sweep FSM states
//   DEFAULT_N_IN    : default number of function inputs (7)
//   DEFAULT_SETTLE  : default settle delay in cycles (1)
//   SETTLE_W        : width of the settle counter (covers 0..15)
//   tt_w(n)         : truth-table width for an n-input function (2**n)
// -----------------------------------------------------------------------------
package pla_harness_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        DONE
    } sweep_state_e;

    localparam int unsigned DEFAULT_N_IN   = 7;
    localparam int unsigned DEFAULT_SETTLE = 1;
    localparam int unsigned SETTLE_W       = 4;

    function automatic int unsigned tt_w(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/sweep_settle_ctr.sv
// -----------------------------------------------------------------------------
// sweep_settle_ctr
// Loadable down-counter that times the settle delay between driving a new
// input vector and sampling the function output.
//   clk, rst   : clock, synchronous active-high reset
//   load       : load load_val (has priority over dec)
//   load_val   : settle delay in cycles
//   dec        : decrement by one (holds at zero)
//   will_zero  : the decrement taking place this cycle brings the count to zero
// -----------------------------------------------------------------------------
module sweep_settle_ctr
    import pla_harness_pkg::*;
#(
    parameter int unsigned W = SETTLE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         will_zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block can infer a latch.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of one means this WAIT cycle is the last one.
    assign will_zero = dec && (cnt_q == W'(1));

endmodule

// File: rtl/pla_sweep_capture.sv
// -----------------------------------------------------------------------------
// pla_sweep_capture
// Sweeps every input vector of an N_IN-input single-output combinational
// function in ascending order, samples the output SETTLE cycles after each new
// vector, packs the samples into a truth table, counts the ON-set minterms and
// offers the result through a valid/ready handshake.
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle sweep request, accepted only in IDLE
//   x_out         : registered input vector to the function (bit0 = x0)
//   y_in          : function output y0
//   busy          : sweep in progress
//   result_valid  : tt_out / ones_cnt are complete
//   result_ready  : consumer accepts the result
//   tt_out        : truth table, bit i = y0 for x_out == i
//   ones_cnt      : number of ON-set minterms
// -----------------------------------------------------------------------------
module pla_sweep_capture
    import pla_harness_pkg::*;
#(
    parameter int unsigned N_IN   = DEFAULT_N_IN,
    parameter int unsigned SETTLE = DEFAULT_SETTLE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [N_IN-1:0]         x_out,
    input  logic                    y_in,
    output logic                    busy,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [tt_w(N_IN)-1:0]   tt_out,
    output logic [N_IN:0]           ones_cnt
);

    localparam int unsigned            TT_BITS  = tt_w(N_IN);
    localparam logic [N_IN:0]          LAST_IDX = {1'b0, {N_IN{1'b1}}};
    localparam logic [N_IN:0]          IDX_ONE  = {{N_IN{1'b0}}, 1'b1};
    localparam logic [SETTLE_W-1:0]    SETTLE_V = SETTLE_W'(SETTLE);

    sweep_state_e         state_q, state_d;
    logic [N_IN:0]        index_q, index_d;
    logic [N_IN-1:0]      x_q, x_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [TT_BITS-1:0]   tt_q, tt_d;
    logic [N_IN:0]        ones_q, ones_d;
    logic                 ctr_load;
    logic                 ctr_dec;
    logic                 ctr_will_zero;

    sweep_settle_ctr #(
        .W (SETTLE_W)
    ) u_settle_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (ctr_load),
        .load_val  (SETTLE_V),
        .dec       (ctr_dec),
        .will_zero (ctr_will_zero)
    );

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        x_d      = x_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        tt_d     = tt_q;
        ones_d   = ones_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    tt_d    = '0;
                    ones_d  = '0;
                    index_d = '0;
                    busy_d  = 1'b1;
                end
            end

            DRIVE: begin
                // x_out only ever moves here, straight from one index to the next.
                x_d      = index_q[N_IN-1:0];
                ctr_load = 1'b1;
                state_d  = (SETTLE == 0) ? SAMPLE : WAIT;
            end

            WAIT: begin
                ctr_dec = 1'b1;
                if (ctr_will_zero) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                tt_d[index_q[N_IN-1:0]] = y_in;
                ones_d = ones_q + {{N_IN{1'b0}}, y_in};
                // The extra index bit keeps this compare from wrapping.
                if (index_q == LAST_IDX) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    index_d = index_q + IDX_ONE;
                    state_d = DRIVE;
                end
            end

            DONE: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the truth table is a plain flop vector rather than a memory,
        // so it is reset with everything else and reads as zero afterwards.
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
            x_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            tt_q    <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
        end
    end

    assign x_out        = x_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign tt_out       = tt_q;
    assign ones_cnt     = ones_q;

endmodule

// File: tb/tb_pla_sweep_capture.sv
// -----------------------------------------------------------------------------
// tb_pla_sweep_capture
// Three DUTs with N_IN = 7 and SETTLE = 1 / 0 / 3 share one stub function
// selector. A table of sweeps is run against the selected DUT; expected
// results go into a scoreboard queue at start and are popped when
// result_valid rises. Hand-written sequences cover reset and start corners.
// -----------------------------------------------------------------------------
module tb_pla_sweep_capture;

    localparam int N  = 7;
    localparam int TT = 128;

    typedef enum int {M_X0, M_ONE, M_ZERO, M_EQ55, M_LAG1} mode_e;

    typedef struct {
        int           sel;
        mode_e        mode;
        int           ready_delay;
        bit           repulse;
        logic [TT-1:0] tt;
        logic [N:0]    ones;
        int           lat;
    } vec_t;

    typedef struct {
        logic [TT-1:0] tt;
        logic [N:0]    ones;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst;
    logic  start;
    logic  ready;
    int    sel;
    mode_e mode;
    logic [2:0] start_v;

    assign start_v = {start && (sel == 2), start && (sel == 1), start && (sel == 0)};

    logic [N-1:0]  x_a, x_b, x_c;
    logic          y_a, y_b, y_c;
    logic          busy_a, busy_b, busy_c;
    logic          valid_a, valid_b, valid_c;
    logic [TT-1:0] tt_a, tt_b, tt_c;
    logic [N:0]    ones_a, ones_b, ones_c;
    logic          lag_a = 1'b0, lag_b = 1'b0, lag_c = 1'b0;

    always @(posedge clk) begin
        lag_a <= x_a[1];
        lag_b <= x_b[1];
        lag_c <= x_c[1];
    end

    function automatic logic stub_y(input mode_e m, input logic [N-1:0] x, input logic lag);
        case (m)
            M_X0:    return x[0];
            M_ONE:   return 1'b1;
            M_ZERO:  return 1'b0;
            M_EQ55:  return x == 7'h55;
            M_LAG1:  return lag;
            default: return 1'b0;
        endcase
    endfunction

    assign y_a = stub_y(mode, x_a, lag_a);
    assign y_b = stub_y(mode, x_b, lag_b);
    assign y_c = stub_y(mode, x_c, lag_c);

    pla_sweep_capture #(.N_IN(7), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .x_out(x_a), .y_in(y_a),
        .busy(busy_a), .result_valid(valid_a), .result_ready(ready),
        .tt_out(tt_a), .ones_cnt(ones_a)
    );

    pla_sweep_capture #(.N_IN(7), .SETTLE(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .x_out(x_b), .y_in(y_b),
        .busy(busy_b), .result_valid(valid_b), .result_ready(ready),
        .tt_out(tt_b), .ones_cnt(ones_b)
    );

    pla_sweep_capture #(.N_IN(7), .SETTLE(3)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .x_out(x_c), .y_in(y_c),
        .busy(busy_c), .result_valid(valid_c), .result_ready(ready),
        .tt_out(tt_c), .ones_cnt(ones_c)
    );

    logic [N-1:0]  x_m;
    logic          busy_m;
    logic          valid_m;
    logic [TT-1:0] tt_m;
    logic [N:0]    ones_m;

    always_comb begin
        x_m = x_a; busy_m = busy_a; valid_m = valid_a; tt_m = tt_a; ones_m = ones_a;
        case (sel)
            1: begin x_m = x_b; busy_m = busy_b; valid_m = valid_b; tt_m = tt_b; ones_m = ones_b; end
            2: begin x_m = x_c; busy_m = busy_c; valid_m = valid_c; tt_m = tt_c; ones_m = ones_c; end
            default: ;
        endcase
    end

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_tt(input string name, input logic [TT-1:0] act, input logic [TT-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %032h expected %032h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t          e;
        int            cnt;
        int            seen;
        bit            stable;
        logic [TT-1:0] tt_hold;
        logic [N:0]    ones_hold;

        @(negedge clk);
        sel   = v.sel;
        mode  = v.mode;
        ready = (v.ready_delay == 0);
        start = 1'b1;
        e.tt = v.tt; e.ones = v.ones; e.lat = v.lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", int'(busy_m), 1);

        // cnt counts posedges after the accept edge.
        cnt = 0;
        while (!valid_m && cnt < v.lat + 64) begin
            @(negedge clk);
            cnt++;
            start = v.repulse && (cnt == 30);
        end
        start = 1'b0;

        check("valid_rise", int'(valid_m), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("latency", cnt, e.lat);
            check_tt("tt_out", tt_m, e.tt);
            check("ones_cnt", int'(ones_m), int'(e.ones));
        end else begin
            check("scoreboard_nonempty", 0, 1);
        end
        check("busy_in_done", int'(busy_m), 0);
        check("x_hold_last", int'(x_m), 127);

        if (v.ready_delay == 0) begin
            @(negedge clk);
            check("valid_drop_early_ready", int'(valid_m), 0);
        end else begin
            tt_hold   = tt_m;
            ones_hold = ones_m;
            stable    = 1'b1;
            for (int i = 0; i < v.ready_delay; i++) begin
                start = v.repulse && (i == 0);
                @(negedge clk);
                if (!valid_m || tt_m !== tt_hold || ones_m !== ones_hold || x_m !== 7'h7f)
                    stable = 1'b0;
            end
            start = 1'b0;
            check("done_stable", int'(stable), 1);
            ready = 1'b1;
            @(negedge clk);
            check("valid_drop_on_ready", int'(valid_m), 0);
            check("idle_after_ready", int'(busy_m), 0);
        end
        ready = 1'b0;

        if (v.repulse) begin
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (valid_m || busy_m) seen++;
            end
            check("no_queued_sweep", seen, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit hit;

        vecs[0] = '{0, M_X0,   0,  1'b0, {32{4'hA}},      8'd64,  384};
        vecs[1] = '{1, M_ONE,  0,  1'b0, {TT{1'b1}},      8'd128, 256};
        vecs[2] = '{1, M_ZERO, 0,  1'b0, {TT{1'b0}},      8'd0,   256};
        vecs[3] = '{0, M_EQ55, 10, 1'b0, 128'd1 << 85,    8'd1,   384};
        vecs[4] = '{2, M_LAG1, 0,  1'b0, {32{4'hC}},      8'd64,  640};
        vecs[5] = '{0, M_X0,   5,  1'b1, {32{4'hA}},      8'd64,  384};

        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        sel   = 0;
        mode  = M_ZERO;
        repeat (3) @(negedge clk);

        check("rst_x_out", int'(x_m), 0);
        check("rst_busy", int'(busy_m), 0);
        check("rst_valid", int'(valid_m), 0);
        check_tt("rst_tt", tt_m, '0);
        check("rst_ones", int'(ones_m), 0);
        rst = 1'b0;

        // rst and start together: rst wins, start is not remembered.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_beats_start", int'(busy_m), 0);
        @(negedge clk);
        check("rst_start_dropped", int'(busy_m), 0);

        // Reset in the middle of a sweep at index 40.
        mode  = M_X0;
        sel   = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (x_m == 7'd40) hit = 1'b1;
            else @(negedge clk);
        end
        check("reach_index_40", int'(hit), 1);
        check("partial_tt_nonzero", int'(tt_m != '0), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_x_out", int'(x_m), 0);
        check("midrst_busy", int'(busy_m), 0);
        check_tt("midrst_tt", tt_m, '0);
        check("midrst_ones", int'(ones_m), 0);
        check("midrst_valid", int'(valid_m), 0);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k]);
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
